mult_accum: RTL and testbench

- Downstream consumer of the 8u x 8s pipelined multiplier.
- Takes its 16-bit two's-complement product stream and sums the products over a frame, giving a signed dot-product result per frame.
- Holds its own valid/last delay line of depth MUL_LAT. Upstream asserts op_valid/op_last in the same cycle it presents operands to the multiplier, and the accumulator lines these flags up with the product.
- Feeds the filter/output stage through a one-cycle acc_valid pulse.

---
 rtl/mult_accum_pkg.sv | 37 +++
 rtl/flag_delay.sv | 60 ++++++
 rtl/mult_accum.sv | 163 ++++++++++++++++
 tb/tb_mult_accum.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_accum_pkg.sv
// mult_accum_pkg: shared constants, FSM state type and the saturating adder
// used by the frame accumulator and the multiplier-latency flag delay line.
//   MUL_LAT_DEF : default multiplier latency (cycles)
//   ACC_W_DEF   : default accumulator width (bits)
//   state_t     : accumulator FSM states
//   sat_add     : signed add clamped to a w-bit signed range (ACC_SAT_EN builds)
package mult_accum_pkg;

  localparam int MUL_LAT_DEF = 8;
  localparam int ACC_W_DEF   = 24;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Operands arrive sign-extended to 64 bits, so the 64-bit sum is exact for
  // any w <= 63; the result is then clamped to the w-bit signed rails.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int                 w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (s > hi) begin
      sat_add = hi;
    end else if (s < lo) begin
      sat_add = lo;
    end else begin
      sat_add = s;
    end
  endfunction

endpackage

// File: rtl/flag_delay.sv
// flag_delay: 2-bit wide, DEPTH-deep shift register that tracks a pair of
// flags (bit 0 = valid, bit 1 = last) through a fixed-latency datapath.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   flush     : synchronous clear of every stage; wins over the new input
//   din       : {last, valid} entering this cycle
//   dout      : {last, valid} at the end of the line
//   any_valid : some valid bit is somewhere in the line
module flag_delay
  import mult_accum_pkg::*;
#(
  parameter int DEPTH = MUL_LAT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic [1:0] din,
  output logic [1:0] dout,
  output logic       any_valid
);

  logic [DEPTH-1:0] vld_d_r;
  logic [DEPTH-1:0] lst_d_r;

  generate
    if (DEPTH == 1) begin : g_one
      // Single-stage line: just a register per flag.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_d_r <= 1'b0;
          lst_d_r <= 1'b0;
        end else if (flush) begin
          vld_d_r <= 1'b0;
          lst_d_r <= 1'b0;
        end else begin
          vld_d_r <= din[0];
          lst_d_r <= din[1];
        end
      end
    end else begin : g_multi
      // Multi-stage line: shift toward the MSB every cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_d_r <= {DEPTH{1'b0}};
          lst_d_r <= {DEPTH{1'b0}};
        end else if (flush) begin
          vld_d_r <= {DEPTH{1'b0}};
          lst_d_r <= {DEPTH{1'b0}};
        end else begin
          vld_d_r <= {vld_d_r[DEPTH-2:0], din[0]};
          lst_d_r <= {lst_d_r[DEPTH-2:0], din[1]};
        end
      end
    end
  endgenerate

  assign dout      = {lst_d_r[DEPTH-1], vld_d_r[DEPTH-1]};
  assign any_valid = |vld_d_r;

endmodule

// File: rtl/mult_accum.sv
// mult_accum: sums the 16-bit signed product stream of the 8u x 8s multiplier
// over a frame and emits one signed dot-product result per frame.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   op_valid  : operand pair presented to the multiplier this cycle
//   op_last   : operand pair ends the frame (qualified by op_valid)
//   clear     : synchronous abort of the open frame and in-flight flags
//   prod      : multiplier result, MUL_LAT cycles after op_valid
//   acc_out   : frame sum, held until the next dump
//   acc_valid : one-cycle pulse when acc_out/acc_cnt/ovf update
//   acc_cnt   : number of products in the dumped frame
//   busy      : frame open or any flag in flight
//   ovf       : dumped frame overflowed
// Optional macro ACC_SAT_EN: saturating accumulation with overflow reporting;
// without it the sum wraps and ovf is constant 0.
module mult_accum
  import mult_accum_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic             op_last,
  input  logic             clear,
  input  logic [15:0]      prod,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  output logic [CNT_W-1:0] acc_cnt,
  output logic             busy,
  output logic             ovf
);

  logic [1:0]       flag_in_s;
  logic [1:0]       flag_out_s;
  logic             d_v_s;
  logic             d_l_s;
  logic             inflight_s;

  state_t           state_r;
  logic [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic [ACC_W-1:0] acc_out_r;
  logic [CNT_W-1:0] acc_cnt_r;
  logic             acc_valid_r;

  logic [ACC_W-1:0] ext_s;
  logic [ACC_W-1:0] base_s;
  logic [ACC_W-1:0] raw_s;
  logic [ACC_W-1:0] sum_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             dump_s;

  assign flag_in_s = {op_valid & op_last, op_valid};

  flag_delay #(
    .DEPTH(MUL_LAT)
  ) u_flag_delay (
    .clk      (clk),
    .rst      (rst),
    .flush    (clear),
    .din      (flag_in_s),
    .dout     (flag_out_s),
    .any_valid(inflight_s)
  );

  assign d_v_s = flag_out_s[0];
  assign d_l_s = flag_out_s[1];

  // Addend selection and frame-end detection; IDLE always adds onto zero.
  always_comb begin
    ext_s = {{(ACC_W-16){prod[15]}}, prod};
    if (state_r == ACCUM) begin
      base_s = acc_r;
    end else begin
      base_s = {ACC_W{1'b0}};
    end
    raw_s     = base_s + ext_s;
    cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    dump_s    = d_v_s & (d_l_s | (cnt_inc_s == CNT_W'(MAX_LEN)));
  end

`ifdef ACC_SAT_EN
  logic add_ovf_s;
  logic ovf_frm_r;
  logic ovf_r;

  // Two's-complement overflow of this addition, before clamping.
  assign add_ovf_s = (base_s[ACC_W-1] == ext_s[ACC_W-1]) &
                     (raw_s[ACC_W-1] != base_s[ACC_W-1]);

  // A clamped accumulator only leaves its rail when the next product points
  // back into range, which the clamp below gives for free.
  assign sum_s = ACC_W'(sat_add({{(64-ACC_W){base_s[ACC_W-1]}}, base_s},
                                {{48{prod[15]}}, prod}, ACC_W));

  // Sticky per-frame overflow flag and its registered copy at dump time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_frm_r <= 1'b0;
      ovf_r     <= 1'b0;
    end else if (clear) begin
      ovf_frm_r <= 1'b0;
    end else if (d_v_s) begin
      if (dump_s) begin
        ovf_r     <= ovf_frm_r | add_ovf_s;
        ovf_frm_r <= 1'b0;
      end else begin
        ovf_frm_r <= ovf_frm_r | add_ovf_s;
      end
    end
  end

  assign ovf = ovf_r;
`else
  assign sum_s = raw_s;
  assign ovf   = 1'b0;
`endif

  // Frame FSM, accumulator and registered result; clear beats any product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_r       <= {ACC_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      acc_out_r   <= {ACC_W{1'b0}};
      acc_cnt_r   <= {CNT_W{1'b0}};
      acc_valid_r <= 1'b0;
    end else begin
      acc_valid_r <= 1'b0;
      if (clear) begin
        state_r <= IDLE;
        acc_r   <= {ACC_W{1'b0}};
        cnt_r   <= {CNT_W{1'b0}};
      end else if (d_v_s) begin
        if (dump_s) begin
          acc_out_r   <= sum_s;
          acc_cnt_r   <= cnt_inc_s;
          acc_valid_r <= 1'b1;
          acc_r       <= {ACC_W{1'b0}};
          cnt_r       <= {CNT_W{1'b0}};
          state_r     <= IDLE;
        end else if (state_r == IDLE) begin
          acc_r   <= ext_s;
          cnt_r   <= {{(CNT_W-1){1'b0}}, 1'b1};
          state_r <= ACCUM;
        end else begin
          acc_r <= sum_s;
          cnt_r <= cnt_inc_s;
        end
      end
    end
  end

  assign acc_out   = acc_out_r;
  assign acc_cnt   = acc_cnt_r;
  assign acc_valid = acc_valid_r;
  assign busy      = (state_r == ACCUM) | inflight_s;

endmodule

// File: tb/tb_mult_accum.sv
// tb_mult_accum: scoreboard bench for mult_accum. A stand-in multiplier
// delays the bench's chosen product by ML cycles; expected frame results are
// queued when the last operand is driven and matched against each acc_valid.
module tb_mult_accum;

  localparam int ML   = 8;
  localparam int AW   = 17;
  localparam int MAXL = 4;
  localparam int CW   = 9;

  typedef struct {
    logic signed [AW-1:0] sum;
    logic [CW-1:0]        cnt;
    logic                 ovf;
    int                   cyc;
  } res_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 op_valid;
  logic                 op_last;
  logic                 clear;
  logic [15:0]          op_val;
  logic [15:0]          prod;
  logic signed [AW-1:0] acc_out;
  logic                 acc_valid;
  logic [CW-1:0]        acc_cnt;
  logic                 busy;
  logic                 ovf;

  logic [ML-1:0][15:0]  pipe;
  int                   cyc = 0;
  int                   checks = 0;
  int                   errors = 0;
  res_t                 exp_q[$];
  res_t                 got_q[$];

  mult_accum #(
    .MUL_LAT(ML),
    .ACC_W  (AW),
    .MAX_LEN(MAXL),
    .CNT_W  (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_last  (op_last),
    .clear    (clear),
    .prod     (prod),
    .acc_out  (acc_out),
    .acc_valid(acc_valid),
    .acc_cnt  (acc_cnt),
    .busy     (busy),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  // Stand-in multiplier: the bench supplies the product itself.
  always @(posedge clk) begin
    pipe <= {pipe[ML-2:0], op_val};
    cyc  <= cyc + 1;
  end
  assign prod = pipe[ML-1];

  // Capture every dump away from the active edge.
  always @(negedge clk) begin : mon
    res_t r;
    if (acc_valid === 1'b1) begin
      r.sum = acc_out;
      r.cnt = acc_cnt;
      r.ovf = ovf;
      r.cyc = cyc;
      got_q.push_back(r);
    end
  end

  task automatic send(input logic [15:0] v, input logic last);
    op_valid = 1'b1;
    op_last  = last;
    op_val   = v;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_last  = 1'b0;
    op_val   = 16'h0000;
  endtask

  // Expected dump cycle for an operand about to be driven now.
  task automatic push_exp(input int s, input int c, input logic o);
    res_t e;
    e.sum = s[AW-1:0];
    e.cnt = c[CW-1:0];
    e.ovf = o;
    e.cyc = cyc + 1 + ML;
    exp_q.push_back(e);
  endtask

  task automatic wait_results(input int n);
    for (int k = 0; k < 200 && got_q.size() < n; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; clear = 1'b0; op_valid = 1'b0; op_last = 1'b0; op_val = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (acc_out !== 17'sd0) begin errors++; $display("FAIL rst_acc_out got %0d exp 0", acc_out); end
    checks++; if (acc_cnt !== 9'd0) begin errors++; $display("FAIL rst_acc_cnt got %0d exp 0", acc_cnt); end
    checks++; if (acc_valid !== 1'b0) begin errors++; $display("FAIL rst_acc_valid got %b exp 0", acc_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", ovf); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_frame;
    res_t e, g;
    send(16'd100, 1'b0);
    send(-16'sd300, 1'b0);
    push_exp(-150, 3, 1'b0);
    send(16'd50, 1'b1);
    wait_results(1);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL frame_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g.sum !== e.sum) begin errors++; $display("FAIL frame_sum got %0d exp %0d", g.sum, e.sum); end
      checks++; if (g.cnt !== e.cnt) begin errors++; $display("FAIL frame_cnt got %0d exp %0d", g.cnt, e.cnt); end
      checks++; if (g.ovf !== e.ovf) begin errors++; $display("FAIL frame_ovf got %b exp %b", g.ovf, e.ovf); end
      checks++; if (g.cyc != e.cyc) begin errors++; $display("FAIL frame_latency got cyc %0d exp cyc %0d", g.cyc, e.cyc); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid;
    res_t e, g;
    send(16'd1, 1'b0);
    send(16'd2, 1'b0);
    send(16'd3, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (acc_out !== 17'sd0) begin errors++; $display("FAIL rstmid_acc_out got %0d exp 0", acc_out); end
    checks++; if (acc_cnt !== 9'd0) begin errors++; $display("FAIL rstmid_acc_cnt got %0d exp 0", acc_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    checks++; if (acc_valid !== 1'b0) begin errors++; $display("FAIL rstmid_acc_valid got %b exp 0", acc_valid); end
    repeat (ML + 2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(16'd5, 1'b0);
    push_exp(12, 2, 1'b0);
    send(16'd7, 1'b1);
    wait_results(1);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g.sum !== e.sum) begin errors++; $display("FAIL rstmid_sum got %0d exp %0d", g.sum, e.sum); end
      checks++; if (g.cnt !== e.cnt) begin errors++; $display("FAIL rstmid_cnt got %0d exp %0d", g.cnt, e.cnt); end
      checks++; if (g.cyc != e.cyc) begin errors++; $display("FAIL rstmid_latency got cyc %0d exp cyc %0d", g.cyc, e.cyc); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back;
    res_t e, g;
    send(16'd10, 1'b0);
    push_exp(30, 2, 1'b0);
    send(16'd20, 1'b1);
    push_exp(-1, 1, 1'b0);
    send(16'hFFFF, 1'b1);
    wait_results(2);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g.sum !== e.sum) begin errors++; $display("FAIL b2b_sum got %0d exp %0d", g.sum, e.sum); end
      checks++; if (g.cnt !== e.cnt) begin errors++; $display("FAIL b2b_cnt got %0d exp %0d", g.cnt, e.cnt); end
      checks++; if (g.cyc != e.cyc) begin errors++; $display("FAIL b2b_slot got cyc %0d exp cyc %0d", g.cyc, e.cyc); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  // clear lands on the cycle the 2nd product sits at the tap; an operand
  // driven in that same cycle must be dropped as well.
  task automatic test_clear;
    send(16'd11, 1'b0);
    send(16'd22, 1'b0);
    send(16'd33, 1'b1);
    repeat (ML - 2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy_before got %b exp 1", busy); end
    clear = 1'b1; op_valid = 1'b1; op_last = 1'b1; op_val = 16'd999;
    @(posedge clk);
    #1;
    clear = 1'b0; op_valid = 1'b0; op_last = 1'b0; op_val = 16'h0000;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy_after got %b exp 0", busy); end
    repeat (ML + 10) @(posedge clk);
    #1;
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL clr_no_dump got %0d pulses exp 0", got_q.size()); end
    checks++; if (acc_out !== -17'sd1) begin errors++; $display("FAIL clr_acc_hold got %0d exp -1", acc_out); end
    checks++; if (acc_cnt !== 9'd1) begin errors++; $display("FAIL clr_cnt_hold got %0d exp 1", acc_cnt); end
    got_q.delete();
  endtask

  task automatic test_max_len;
    res_t e, g;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) push_exp(4000, 4, 1'b0);
      send(16'd1000, 1'b0);
    end
    wait_results(1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL maxlen_busy got %b exp 1", busy); end
    push_exp(2000, 3, 1'b0);
    send(16'd0, 1'b1);
    wait_results(2);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL maxlen_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g.sum !== e.sum) begin errors++; $display("FAIL maxlen_sum got %0d exp %0d", g.sum, e.sum); end
      checks++; if (g.cnt !== e.cnt) begin errors++; $display("FAIL maxlen_cnt got %0d exp %0d", g.cnt, e.cnt); end
      checks++; if (g.cyc != e.cyc) begin errors++; $display("FAIL maxlen_latency got cyc %0d exp cyc %0d", g.cyc, e.cyc); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_overflow;
    res_t e, g;
    send(16'd32767, 1'b0);
    send(16'd32767, 1'b0);
`ifdef ACC_SAT_EN
    push_exp(65535, 3, 1'b1);
`else
    push_exp(-32771, 3, 1'b0);
`endif
    send(16'd32767, 1'b1);
    push_exp(1, 1, 1'b0);
    send(16'd1, 1'b1);
    wait_results(2);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g.sum !== e.sum) begin errors++; $display("FAIL ovf_sum got %0d exp %0d", g.sum, e.sum); end
      checks++; if (g.cnt !== e.cnt) begin errors++; $display("FAIL ovf_cnt got %0d exp %0d", g.cnt, e.cnt); end
      checks++; if (g.ovf !== e.ovf) begin errors++; $display("FAIL ovf_flag got %b exp %b", g.ovf, e.ovf); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    test_reset();
    test_frame();
    test_reset_mid();
    test_back_to_back();
    test_clear();
    test_max_len();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
